// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame constants and baud divider helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count, full and empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_rd, do_wr;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  // A read frees the head slot, so a write into a full FIFO is taken when it coincides with a read
  always_comb begin
    mem_d = mem_q;
    if (do_wr) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end
  // Storage is not reset; clearing the count and pointers discards every queued entry
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter, LSB first, fed from a write-side byte FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [7:0]                        wr_data,
  input  logic                              wr_en,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              busy,
  output logic                              tx
);
  localparam int DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  uart_tx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, rd_data;
  logic tx_q, tx_d, busy_q, busy_d, overflow_q, overflow_d;
  logic tick, start_ok, pop;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );
  assign tick     = state_q != IDLE && cnt_q == CNT_MAX;
  assign start_ok = en && !fifo_empty;
  assign pop      = start_ok && (state_q == IDLE || (state_q == STOP && tick));
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  // State and datapath registers; reset aborts any frame and returns the line to idle-high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end
  // Frame sequencing; a pending byte at the end of STOP chains straight into the next START
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && bit_q == LAST_BIT) state_d = STOP;
      STOP:    if (tick) state_d = start_ok ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Next line level, shifter and bit index, computed so tx comes straight from a flop
  always_comb begin
    cnt_d      = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = state_d != IDLE;
    overflow_d = wr_en && fifo_full && !pop;
    if (pop) begin
      shift_d = rd_data;
      tx_d    = 1'b0;
    end else if (tick && (state_q == START || (state_q == DATA && bit_q != LAST_BIT))) begin
      tx_d    = shift_q[0];
      shift_d = shift_q >> 1;
      bit_d   = state_q == START ? 3'd0 : bit_q + 3'd1;
    end else if (tick) begin
      tx_d = 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a frame-level model
module tb_uart_tx_fifo;
  localparam int DIV   = 86;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int FRAME = 10 * DIV;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic fifo_full, fifo_empty, overflow, busy, tx;
  logic [CW-1:0] fifo_count;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy),
    .tx         (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the cycle offset t within the frame on the line
  logic [7:0] mq[$];
  int t = -1;
  logic [7:0] cur = 8'h00;
  logic movf = 1'b0, m_active, m_fin, m_pop;

  function automatic logic exp_tx();
    int b;
    if (t < 0) return 1'b1;
    b = t / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      t = -1;
      movf = 1'b0;
    end else begin
      m_active = t >= 0;
      m_fin    = m_active && t == FRAME - 1;
      m_pop    = en && mq.size() > 0 && (!m_active || m_fin);
      movf     = wr_en && mq.size() == DEPTH && !m_pop;
      if (m_pop) begin
        cur = mq.pop_front();
        t = 0;
      end else if (m_active && !m_fin) t++;
      else t = -1;
      if (wr_en && !movf) mq.push_back(wr_data);
    end
    #1;
    check("tx", tx, exp_tx());
    check("busy", busy, t >= 0);
    check("fifo", {overflow, fifo_full, fifo_empty, fifo_count},
          {movf, mq.size() == DEPTH, mq.size() == 0, CW'(mq.size())});
  end

  // Line monitor: decodes frames by sampling each bit at its middle
  logic [7:0] dec[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_b;
  logic mon_prev = 1'b1;
  int bad_stop = 0;
  initial forever begin
    @(negedge clk);
    if (mon_prev && !tx) begin
      repeat (DIV / 2) @(negedge clk);
      if (!tx) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (!tx) bad_stop++;
        dec.push_back(mon_b);
      end
    end
    mon_prev = tx;
  end

  task automatic drive(input logic r, input logic e, input logic w, input logic [7:0] d);
    @(negedge clk);
    rst_n = r;
    en = e;
    wr_en = w;
    wr_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, en, 1'b0, 8'($urandom));
  endtask

  task automatic mon_check(input string tag, input int budget);
    int k = 0;
    while (dec.size() < exp_q.size() && k < budget) begin
      idle(1);
      k++;
    end
    check({tag, "_n"}, dec.size(), exp_q.size());
    while (exp_q.size() > 0) check(tag, dec.size() > 0 ? dec.pop_front() : 8'hxx, exp_q.pop_front());
    dec.delete();
  endtask

  initial begin
    logic [7:0] hi [4];
    int wp;
    hi = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("rst", {tx, busy, fifo_empty, fifo_count}, {1'b1, 1'b0, 1'b1, 4'd0});
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    idle(1000);
    check("idle", {tx, busy}, {1'b1, 1'b0});

    drive(1'b1, 1'b1, 1'b1, 8'h55);
    drive(1'b1, 1'b1, 1'b0, 8'hAA);
    check("t2_stored", {tx, busy, fifo_count}, {1'b1, 1'b0, 4'd1});
    idle(1);
    check("t2_start", {tx, busy, fifo_count}, {1'b0, 1'b1, 4'd0});
    idle(DIV);
    check("t2_bit0", tx, 1'b1);
    idle(DIV);
    check("t2_bit1", tx, 1'b0);
    idle(FRAME - 1 - 2 * DIV);
    check("t2_stop", {tx, busy}, {1'b1, 1'b1});
    idle(1);
    check("t2_done", {tx, busy}, {1'b1, 1'b0});
    exp_q.push_back(8'h55);
    mon_check("t2_mon", 200);

    foreach (hi[i]) begin
      drive(1'b1, 1'b1, 1'b1, hi[i]);
      exp_q.push_back(hi[i]);
    end
    mon_check("t3_mon", 4 * FRAME + 200);
    idle(100);

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(i));
      if (i == 8) check("t4_full", {fifo_full, fifo_count, overflow}, {1'b1, 4'd8, 1'b0});
    end
    drive(1'b1, 1'b0, 1'b0, 8'h99);
    check("t4_ovf", {overflow, fifo_count}, {1'b1, 4'd8});
    drive(1'b1, 1'b0, 1'b0, 8'h99);
    check("t4_ovf_clr", {overflow, fifo_count}, {1'b0, 4'd8});
    drive(1'b1, 1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    mon_check("t4_mon", 8 * FRAME + 200);
    idle(100);

    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
    drive(1'b1, 1'b1, 1'b1, 8'h18);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("t5", {overflow, fifo_full, fifo_count, busy}, {1'b0, 1'b1, 4'd8, 1'b1});
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h10 + i));
    mon_check("t5_mon", 9 * FRAME + 200);
    idle(100);
    check("stop_bits", bad_stop, 0);

    drive(1'b1, 1'b1, 1'b1, 8'hA5);
    drive(1'b1, 1'b1, 1'b1, 8'hB0);
    drive(1'b1, 1'b1, 1'b1, 8'hB1);
    drive(1'b1, 1'b1, 1'b1, 8'hB2);
    idle(377);
    check("t6_bit3", {tx, busy, fifo_count}, {1'b0, 1'b1, 4'd3});
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("t6_rst", {tx, busy, fifo_empty, fifo_count}, {1'b1, 1'b0, 1'b1, 4'd0});
    idle(1000);
    check("t6_quiet", {tx, busy, fifo_count}, {1'b1, 1'b0, 4'd0});
    dec.delete();

    wp = 1;
    for (int c = 0; c < 25000; c++) begin
      if (c % 2000 == 0) wp = $urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) ? 1 : 30);
      drive($urandom_range(0, 4999) != 0,
            $urandom_range(0, 999) < 5 ? ~en : en,
            $urandom_range(0, 99) < wp,
            8'($urandom));
    end
    dec.delete();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
